uart_rx_ctrl: RTL and testbench

Frame-sequencing state machine for the UART receiver. Detects the start-bit falling edge and enables the oversampling edge/bit counter. From the counter values it times the sampler, deserializer and start/parity/stop checkers. It also issues the frame-level result: data valid, parity error or framing error. It sits between the synchronized RX line and the RX datapath blocks.

---
 rtl/uart_rx_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Frame-sequencing state machine for the UART receiver. Watches the
// synchronized RX line for a start-bit falling edge, runs the external
// oversampling edge/bit counter for the length of a frame, and strobes the
// sampler, deserializer and start/parity/stop checkers on the last
// oversampling edge of each bit. At the end of every completed frame it
// emits a one-cycle result: DATA_VALID, PARITY_ERROR and/or FRAMING_ERROR.
//
// Ports
//   CLK            receiver clock (PRESCALE x bit rate)
//   RST            asynchronous, active-low reset
//   RX_IN          synchronized serial line, idle high
//   PAR_EN         parity bit present (latched on frame start)
//   PRESCALE[5:0]  oversampling ratio (8, 16 or 32)
//   EDGE_CNT[5:0]  edge index within the current bit (from counter)
//   BIT_CNT[3:0]   bit index within the frame, 0 = start bit (from counter)
//   STRT_GLITCH    start checker: sampled start bit was 1
//   PAR_ERR        parity checker: mismatch
//   STP_ERR        stop checker: sampled stop bit was 0
//   CNT_EN         counter enable
//   DAT_SAMP_EN    sampler enable
//   DESER_EN       shift the sampled bit into the deserializer
//   STRT_CHK_EN    start checker strobe
//   PAR_CHK_EN     parity checker strobe
//   STP_CHK_EN     stop checker strobe
//   DATA_VALID     one-cycle pulse, received byte good
//   PARITY_ERROR   one-cycle pulse, frame parity failed
//   FRAMING_ERROR  one-cycle pulse, stop bit low
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] PRESCALE,
    input  logic [5:0] EDGE_CNT,
    input  logic [3:0] BIT_CNT,
    input  logic       STRT_GLITCH,
    input  logic       PAR_ERR,
    input  logic       STP_ERR,
    output logic       CNT_EN,
    output logic       DAT_SAMP_EN,
    output logic       DESER_EN,
    output logic       STRT_CHK_EN,
    output logic       PAR_CHK_EN,
    output logic       STP_CHK_EN,
    output logic       DATA_VALID,
    output logic       PARITY_ERROR,
    output logic       FRAMING_ERROR
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        OUT    = 3'd5
    } state_t;

    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    state_t state_r;
    state_t state_s;
    logic   armed_r;
    logic   par_en_r;
    logic   par_flag_r;
    logic   frm_flag_r;
    logic   last_edge_s;
    logic   enter_start_s;

    // All bit-level actions happen on the final oversampling edge of a bit.
    assign last_edge_s   = (EDGE_CNT == (PRESCALE - 6'd1));
    // Covers both IDLE->START and the back-to-back OUT->START path.
    assign enter_start_s = (state_s == START) && (state_r != START);

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!RX_IN && armed_r) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (last_edge_s) begin
                    if (STRT_GLITCH) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (last_edge_s && (BIT_CNT == LAST_DATA_BIT)) begin
                    if (par_en_r) begin
                        state_s = PARITY;
                    end else begin
                        state_s = STOP;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (last_edge_s) begin
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (last_edge_s) begin
                    state_s = OUT;
                end else begin
                    state_s = STOP;
                end
            end
            OUT: begin
                // A framing error usually means a break; never restart on it.
                if (!RX_IN && !frm_flag_r) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from registered state, counters and flags only.
    always_comb begin
        CNT_EN        = 1'b0;
        DAT_SAMP_EN   = 1'b0;
        DESER_EN      = 1'b0;
        STRT_CHK_EN   = 1'b0;
        PAR_CHK_EN    = 1'b0;
        STP_CHK_EN    = 1'b0;
        DATA_VALID    = 1'b0;
        PARITY_ERROR  = 1'b0;
        FRAMING_ERROR = 1'b0;
        case (state_r)
            START: begin
                CNT_EN      = 1'b1;
                DAT_SAMP_EN = 1'b1;
                STRT_CHK_EN = last_edge_s;
            end
            DATA: begin
                CNT_EN      = 1'b1;
                DAT_SAMP_EN = 1'b1;
                if (last_edge_s && (BIT_CNT >= 4'd1) && (BIT_CNT <= LAST_DATA_BIT)) begin
                    DESER_EN = 1'b1;
                end else begin
                    DESER_EN = 1'b0;
                end
            end
            PARITY: begin
                CNT_EN      = 1'b1;
                DAT_SAMP_EN = 1'b1;
                PAR_CHK_EN  = last_edge_s;
            end
            STOP: begin
                CNT_EN      = 1'b1;
                DAT_SAMP_EN = 1'b1;
                STP_CHK_EN  = last_edge_s;
            end
            OUT: begin
                DATA_VALID    = !par_flag_r && !frm_flag_r;
                PARITY_ERROR  = par_flag_r;
                FRAMING_ERROR = frm_flag_r;
            end
            default: begin
                CNT_EN = 1'b0;
            end
        endcase
    end

    // Start detection is armed only after the line has been seen idle high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            armed_r <= 1'b0;
        end else if ((state_r == OUT) && frm_flag_r) begin
            armed_r <= 1'b0;
        end else if (RX_IN) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

    // Frame-static parity enable, so a mid-frame PAR_EN change has no effect.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_r <= 1'b0;
        end else if (enter_start_s) begin
            par_en_r <= PAR_EN;
        end else begin
            par_en_r <= par_en_r;
        end
    end

    // Parity and framing error flags, cleared at each frame start.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_flag_r <= 1'b0;
            frm_flag_r <= 1'b0;
        end else if (enter_start_s) begin
            par_flag_r <= 1'b0;
            frm_flag_r <= 1'b0;
        end else begin
            if ((state_r == PARITY) && last_edge_s) begin
                par_flag_r <= PAR_ERR;
            end else begin
                par_flag_r <= par_flag_r;
            end
            if ((state_r == STOP) && last_edge_s) begin
                frm_flag_r <= STP_ERR;
            end else begin
                frm_flag_r <= frm_flag_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl. Provides the oversampling counter
// and the three checkers as environment models, drives whole frames on RX_IN
// and compares what the controller does against frame-level expectations
// (CNT_EN duration, result pulse position, strobe counts).
module tb_uart_rx_ctrl;

    localparam int DW = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic [5:0] PRESCALE = 6'd8;
    logic [5:0] EDGE_CNT;
    logic [3:0] BIT_CNT;
    logic       STRT_GLITCH, PAR_ERR, STP_ERR;
    logic       CNT_EN, DAT_SAMP_EN, DESER_EN;
    logic       STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN;
    logic       DATA_VALID, PARITY_ERROR, FRAMING_ERROR;
    logic       cfg_glitch = 1'b0, cfg_perr = 1'b0, cfg_serr = 1'b0;
    logic [8:0] outs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN),
        .PRESCALE(PRESCALE), .EDGE_CNT(EDGE_CNT), .BIT_CNT(BIT_CNT),
        .STRT_GLITCH(STRT_GLITCH), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
        .CNT_EN(CNT_EN), .DAT_SAMP_EN(DAT_SAMP_EN), .DESER_EN(DESER_EN),
        .STRT_CHK_EN(STRT_CHK_EN), .PAR_CHK_EN(PAR_CHK_EN), .STP_CHK_EN(STP_CHK_EN),
        .DATA_VALID(DATA_VALID), .PARITY_ERROR(PARITY_ERROR), .FRAMING_ERROR(FRAMING_ERROR)
    );

    always #5 CLK = ~CLK;

    // Checkers answer their strobe combinationally.
    assign STRT_GLITCH = STRT_CHK_EN & cfg_glitch;
    assign PAR_ERR     = PAR_CHK_EN & cfg_perr;
    assign STP_ERR     = STP_CHK_EN & cfg_serr;
    assign outs = {CNT_EN, DAT_SAMP_EN, DESER_EN, STRT_CHK_EN, PAR_CHK_EN,
                   STP_CHK_EN, DATA_VALID, PARITY_ERROR, FRAMING_ERROR};

    // Oversampling edge/bit counter environment model.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            EDGE_CNT <= 6'd0;
            BIT_CNT  <= 4'd0;
        end else if (!CNT_EN) begin
            EDGE_CNT <= 6'd0;
            BIT_CNT  <= 4'd0;
        end else if (EDGE_CNT == PRESCALE - 6'd1) begin
            EDGE_CNT <= 6'd0;
            BIT_CNT  <= BIT_CNT + 4'd1;
        end else begin
            EDGE_CNT <= EDGE_CNT + 6'd1;
        end
    end

    typedef struct {
        int             p;
        bit             pe;
        logic [DW-1:0]  data;
        bit             glitch;
        bit             perr;
        bit             serr;
        int             exp_cnt;   // CNT_EN cycles == index of the OUT cycle
        bit             exp_dv;
        bit             exp_pe;
        bit             exp_fe;
        int             exp_deser;
    } vec_t;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Line level k cycles after START entry: start, data LSB first, even parity, stop.
    function automatic logic line_val(input int k, input vec_t v);
        int b;
        if (v.glitch) return (k < 2) ? 1'b0 : 1'b1;
        b = k / v.p;
        if (b == 0) return 1'b0;
        if (b <= DW) return v.data[b-1];
        if (v.pe && (b == DW + 1)) return ^v.data;
        return v.serr ? 1'b0 : 1'b1;
    endfunction

    // Reference expectations derived from the frame rules.
    function automatic vec_t model(input int p, input bit pe, input logic [DW-1:0] data,
                                   input bit glitch, input bit perr, input bit serr);
        vec_t v;
        v.p = p; v.pe = pe; v.data = data; v.glitch = glitch; v.perr = perr; v.serr = serr;
        v.exp_cnt   = glitch ? p : (2 + DW + int'(pe)) * p;
        v.exp_pe    = !glitch && pe && perr;
        v.exp_fe    = !glitch && serr;
        v.exp_dv    = !glitch && !v.exp_pe && !v.exp_fe;
        v.exp_deser = glitch ? 0 : DW;
        return v;
    endfunction

    // Runs one frame. started=1 means the DUT already entered START this cycle.
    task automatic run_frame(input vec_t v, input bit started, input bit b2b,
                             output int dv_cycle);
        int w, n_cnt, n_dv, n_pe, n_fe, i_dv, i_pe, i_fe, n_des, n_bad, n_sc, n_pc, n_tc;
        n_cnt = 0; n_dv = 0; n_pe = 0; n_fe = 0; i_dv = -1; i_pe = -1; i_fe = -1;
        n_des = 0; n_bad = 0; n_sc = 0; n_pc = 0; n_tc = 0; dv_cycle = -1;
        PRESCALE = 6'(v.p); PAR_EN = v.pe;
        cfg_glitch = v.glitch; cfg_perr = v.perr; cfg_serr = v.serr;
        if (!started) begin
            RX_IN = 1'b1; tick();
            RX_IN = 1'b0; tick();
        end
        w = v.glitch ? v.p + 2 : v.exp_cnt;
        for (int k = 0; k <= w; k++) begin
            RX_IN = (b2b && k == w) ? 1'b0 : line_val(k, v);
            if (CNT_EN) n_cnt++;
            if (DESER_EN) begin
                n_des++;
                if (EDGE_CNT != 6'(v.p - 1)) n_bad++;
            end
            if (STRT_CHK_EN) n_sc++;
            if (PAR_CHK_EN) n_pc++;
            if (STP_CHK_EN) n_tc++;
            if (DATA_VALID) begin n_dv++; i_dv = k; dv_cycle = cyc; end
            if (PARITY_ERROR) begin n_pe++; i_pe = k; end
            if (FRAMING_ERROR) begin n_fe++; i_fe = k; end
            if (k < w) tick();
        end
        tick();
        if (!b2b) check("idle_after_frame", outs, 0);
        check("cnt_en_cycles", n_cnt, v.exp_cnt);
        check("data_valid_count", n_dv, v.exp_dv);
        check("data_valid_index", i_dv, v.exp_dv ? v.exp_cnt : -1);
        check("parity_error_count", n_pe, v.exp_pe);
        check("parity_error_index", i_pe, v.exp_pe ? v.exp_cnt : -1);
        check("framing_error_count", n_fe, v.exp_fe);
        check("framing_error_index", i_fe, v.exp_fe ? v.exp_cnt : -1);
        check("deser_count", n_des, v.exp_deser);
        check("deser_off_last_edge", n_bad, 0);
        check("strt_chk_count", n_sc, 1);
        check("par_chk_count", n_pc, (v.pe && !v.glitch) ? 1 : 0);
        check("stp_chk_count", n_tc, v.glitch ? 0 : 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t v, v2;
        int d1, d2, n;

        // p, pe, data, glitch, perr, serr, exp_cnt, dv, pe, fe, deser
        tbl[0] = '{8,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 80,  1'b1, 1'b0, 1'b0, 8};
        tbl[1] = '{16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 176, 1'b0, 1'b1, 1'b0, 8};
        tbl[2] = '{8,  1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8,   1'b0, 1'b0, 1'b0, 0};
        tbl[3] = '{32, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 352, 1'b1, 1'b0, 1'b0, 8};
        tbl[4] = '{16, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 160, 1'b0, 1'b0, 1'b1, 8};
        tbl[5] = '{8,  1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 88,  1'b0, 1'b1, 1'b1, 8};
        tbl[6] = '{32, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 320, 1'b1, 1'b0, 1'b0, 8};
        tbl[7] = '{16, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b1, 176, 1'b0, 1'b0, 1'b1, 8};

        // Reset behaviour and arming.
        #2 RST = 1'b0;
        tick(); tick();
        check("outputs_in_reset", outs, 0);
        @(negedge CLK) RST = 1'b1;
        #1 check("outputs_after_release", outs, 0);
        RX_IN = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (CNT_EN) n++; end
        check("no_start_before_armed", n, 0);

        // Table-driven frames.
        foreach (tbl[i]) run_frame(tbl[i], 1'b0, 1'b0, d1);

        // Back-to-back frames.
        v = model(8, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0);
        v2 = model(8, 1'b0, 8'hE7, 1'b0, 1'b0, 1'b0);
        run_frame(v, 1'b0, 1'b1, d1);
        check("b2b_second_start", {CNT_EN, EDGE_CNT, BIT_CNT}, {1'b1, 6'd0, 4'd0});
        run_frame(v2, 1'b1, 1'b0, d2);
        check("b2b_pulse_spacing", d2 - d1, 81);

        // Break: framing error with line held low must not restart.
        v = model(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        run_frame(v, 1'b0, 1'b0, d1);
        RX_IN = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (CNT_EN) n++; end
        check("break_no_restart", n, 0);
        RX_IN = 1'b1; tick();
        RX_IN = 1'b0; tick();
        check("break_rearm_start", CNT_EN, 1);
        v = model(8, 1'b0, 8'h3B, 1'b0, 1'b0, 1'b0);
        run_frame(v, 1'b1, 1'b0, d1);

        // Reset in the middle of the data bits.
        PRESCALE = 6'd16; PAR_EN = 1'b0; cfg_glitch = 1'b0; cfg_perr = 1'b0; cfg_serr = 1'b0;
        RX_IN = 1'b1; tick();
        RX_IN = 1'b0; tick();
        for (int i = 0; i < 67; i++) tick();
        check("midreset_precondition", {DAT_SAMP_EN, BIT_CNT}, {1'b1, 4'd4});
        RST = 1'b0;
        #1 check("midreset_outputs_zero", outs, 0);
        tick();
        check("midreset_held", outs, 0);
        @(negedge CLK) RST = 1'b1;
        RX_IN = 1'b1;
        tick();
        check("midreset_first_cycle", outs, 0);
        v = model(16, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0);
        run_frame(v, 1'b0, 1'b0, d1);

        // Randomized frames against the reference model.
        for (int i = 0; i < 16; i++) begin
            v = model(8 << $urandom_range(2, 0), 1'($urandom_range(1, 0)),
                      8'($urandom_range(255, 0)), $urandom_range(7, 0) == 0,
                      $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0);
            run_frame(v, 1'b0, 1'b0, d1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
